// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_i over a
// window of GATE_CYCLES system clocks and publishes the saturated count.
module freq_meter #(
    parameter int FREQ_SYSCLK = 12_000_000,
    parameter int GATE_CYCLES = 12_000_000,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_n_i,
    input  logic                 sig_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] freq_o,
    output logic                 freq_vld_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    localparam logic [24:0]          GATE_LAST = 25'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    // Out-of-range parameters leave a visible marker block in the hierarchy.
    if (FREQ_SYSCLK <= 0 || GATE_CYCLES < 2 || GATE_CYCLES > 33_554_431) begin : g_illegal_params
    end

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [24:0]          r_gate_cnt;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic                 r_ovf_flag;

    logic                 w_edge;
    logic                 w_at_max;
    logic                 w_ovf_hit;
    logic                 w_win_end;
    logic [CNT_WIDTH-1:0] w_edge_sum;

    assign w_edge     = r_sync2 & ~r_prev;
    assign w_at_max   = (r_edge_cnt == CNT_MAX);
    assign w_ovf_hit  = w_edge & w_at_max;
    assign w_win_end  = (r_gate_cnt == GATE_LAST);
    assign w_edge_sum = (w_edge && !w_at_max) ? r_edge_cnt + CNT_WIDTH'(1) : r_edge_cnt;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
            freq_o     <= '0;
            ovf_o      <= 1'b0;
            freq_vld_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            // The synchroniser runs regardless of state so edge detection is
            // already settled when a window opens.
            r_sync1    <= sig_i;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            freq_vld_o <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state    <= S_GATE;
                        busy_o     <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_flag <= 1'b0;
                    end
                end
                S_GATE: begin
                    if (w_win_end) begin
                        // Window end wins over a simultaneous enable drop.
                        freq_o     <= w_edge_sum;
                        ovf_o      <= r_ovf_flag | w_ovf_hit;
                        freq_vld_o <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_flag <= 1'b0;
                        if (!en_i) begin
                            r_state <= S_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else if (!en_i) begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + 25'd1;
                        r_edge_cnt <= w_edge_sum;
                        r_ovf_flag <= r_ovf_flag | w_ovf_hit;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Randomised bench for freq_meter: two instances (100- and 1000-cycle gates)
// checked every cycle against a window-counting reference model.
module tb_freq_meter;

    localparam int GA   = 100;
    localparam int GB   = 1000;
    localparam int W    = 8;
    localparam int MAXC = 16384;
    localparam int CMAX = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sig   = 1'b0;
    logic en    = 1'b0;

    logic [W-1:0] freq_a, freq_b;
    logic         vld_a, vld_b, ovf_a, ovf_b, busy_a, busy_b;

    always #5 clk = ~clk;

    freq_meter #(.FREQ_SYSCLK(100_000_000), .GATE_CYCLES(GA), .CNT_WIDTH(W)) u_dut_a (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .sig_i     (sig),
        .en_i      (en),
        .freq_o    (freq_a),
        .freq_vld_o(vld_a),
        .ovf_o     (ovf_a),
        .busy_o    (busy_a)
    );

    freq_meter #(.FREQ_SYSCLK(100_000_000), .GATE_CYCLES(GB), .CNT_WIDTH(W)) u_dut_b (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .sig_i     (sig),
        .en_i      (en),
        .freq_o    (freq_b),
        .freq_vld_o(vld_b),
        .ovf_o     (ovf_b),
        .busy_o    (busy_b)
    );

    int   n_cmp = 0;
    int   n_mis = 0;
    logic h [MAXC];       // sig_i as sampled on each rising edge (0 while in reset)
    int   p = -1;         // index of the most recent rising edge
    int   gate_len [2] = '{GA, GB};
    int   m_start  [2];   // rising-edge index at which the window opened, -1 when idle
    int   m_freq   [2];
    int   m_ovf    [2];
    int   m_vld    [2];

    int   g_mode   = 0;   // 0 constant, 1 square wave, 2 random noise
    int   g_period = 10;
    int   g_phase  = 0;
    logic g_const  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, p);
        end
    endtask

    // Edges counted in a window = rising transitions of the sampled input,
    // each credited one sample later than the sample where it first shows.
    function automatic int count_edges(input int s, input int e);
        int raw = 0;
        for (int m = s; m <= e; m++)
            if (m >= 2 && h[m-1] && !h[m-2]) raw++;
        return raw;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_start[d] = -1; m_freq[d] = 0; m_ovf[d] = 0; m_vld[d] = 0;
        end
    endtask

    task automatic model_edge(input logic rst_s, input logic en_s);
        int raw;
        for (int d = 0; d < 2; d++) begin
            if (!rst_s) begin
                m_start[d] = -1; m_freq[d] = 0; m_ovf[d] = 0; m_vld[d] = 0;
            end else begin
                m_vld[d] = 0;
                if (m_start[d] < 0) begin
                    if (en_s) m_start[d] = p;
                end else if (p == m_start[d] + gate_len[d]) begin
                    raw        = count_edges(m_start[d], p - 1);
                    m_freq[d]  = (raw > CMAX) ? CMAX : raw;
                    m_ovf[d]   = (raw > CMAX) ? 1 : 0;
                    m_vld[d]   = 1;
                    m_start[d] = en_s ? p : -1;
                end else if (!en_s) begin
                    m_start[d] = -1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_val("a_busy", 32'(busy_a), 32'(m_start[0] >= 0));
        check_val("a_vld",  32'(vld_a),  32'(m_vld[0]));
        check_val("a_freq", 32'(freq_a), 32'(m_freq[0]));
        check_val("a_ovf",  32'(ovf_a),  32'(m_ovf[0]));
        check_val("b_busy", 32'(busy_b), 32'(m_start[1] >= 0));
        check_val("b_vld",  32'(vld_b),  32'(m_vld[1]));
        check_val("b_freq", 32'(freq_b), 32'(m_freq[1]));
        check_val("b_ovf",  32'(ovf_b),  32'(m_ovf[1]));
    endtask

    task automatic next_sig();
        case (g_mode)
            0:       sig = g_const;
            1: begin
                sig     = (g_phase < g_period / 2) ? 1'b1 : 1'b0;
                g_phase = (g_phase + 1) % g_period;
            end
            default: sig = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_square(input int per);
        g_mode = 1; g_period = per; g_phase = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        next_sig();
        @(posedge clk);
        p++;
        if (p >= MAXC) begin
            $display("FAIL history_overflow: observed %0d expected below %0d", p, MAXC);
            $fatal(1, "history exhausted");
        end
        h[p] = rst_n ? sig : 1'b0;
        model_edge(rst_n, en);
        #1;
        check_outputs();
    endtask

    initial begin
        int b_win, last_vld, n_vld, saved, k, per;
        model_reset();

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Continuous enable: period 10, then period 2, then period 10 again
        set_square(10);
        en       = 1'b1;
        b_win    = 0;
        last_vld = -1;
        for (int c = 0; c <= 3000; c++) begin
            if (c == 1000) set_square(2);
            if (c == 2000) set_square(10);
            tick();
            if (vld_a && c <= 1000) begin
                check_val("a_p10_freq_range", 32'(freq_a >= 9 && freq_a <= 11), 32'd1);
                check_val("a_p10_ovf", 32'(ovf_a), 32'd0);
            end
            if (vld_a) begin
                if (last_vld >= 0) check_val("a_vld_period", 32'(p - last_vld), 32'd100);
                last_vld = p;
            end
            if (vld_b) begin
                b_win++;
                if (b_win == 1) check_val("b_win1_freq", 32'(freq_b), 32'd100);
                if (b_win == 2) begin
                    check_val("b_win2_freq", 32'(freq_b), 32'd255);
                    check_val("b_win2_ovf",  32'(ovf_b),  32'd1);
                end
                if (b_win == 3) begin
                    check_val("b_win3_freq_range", 32'(freq_b >= 99 && freq_b <= 101), 32'd1);
                    check_val("b_win3_ovf", 32'(ovf_b), 32'd0);
                end
            end
        end
        check_val("b_window_count", 32'(b_win), 32'd3);

        // Input stuck high: zero count, pulses keep coming every 100 cycles
        g_mode  = 0;
        g_const = 1'b1;
        n_vld   = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (vld_a) begin
                n_vld++;
                check_val("a_vld_period_const", 32'(p - last_vld), 32'd100);
                last_vld = p;
                if (n_vld > 1) begin
                    check_val("a_const_freq", 32'(freq_a), 32'd0);
                    check_val("a_const_ovf",  32'(ovf_a),  32'd0);
                end
            end
        end
        check_val("a_const_vld_count", 32'(n_vld), 32'd3);

        // Enable dropped 50 cycles into a window
        set_square(7);
        k = 0;
        while (p != m_start[0] + 49 && k < 300) begin tick(); k++; end
        check_val("abort_align", 32'(p == m_start[0] + 49), 32'd1);
        saved = int'(freq_a);
        en = 1'b0;
        tick();
        check_val("abort_busy", 32'(busy_a), 32'd0);
        check_val("abort_freq_kept", 32'(freq_a), 32'(saved));
        n_vld = 0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (vld_a) n_vld++;
        end
        check_val("abort_no_vld", 32'(n_vld), 32'd0);
        check_val("abort_freq_kept_late", 32'(freq_a), 32'(saved));

        // Enable from idle; one edge arriving just before window end
        g_mode  = 0;
        g_const = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        tick();
        check_val("busy_on", 32'(busy_a), 32'd1);
        k = 0;
        while (p != m_start[0] + GA - 2 && k < 300) begin tick(); k++; end
        check_val("late_edge_align", 32'(p == m_start[0] + GA - 2), 32'd1);
        g_const = 1'b1;
        tick();
        tick();
        check_val("late_edge_cur_vld",  32'(vld_a),  32'd1);
        check_val("late_edge_cur_freq", 32'(freq_a), 32'd0);
        k = 0;
        do begin tick(); k++; end while (!vld_a && k < 200);
        check_val("late_edge_next_gap",  32'(k), 32'd100);
        check_val("late_edge_next_freq", 32'(freq_a), 32'd1);

        // Asynchronous reset 60 cycles into a window
        set_square(5);
        k = 0;
        while (p != m_start[0] + 60 && k < 300) begin tick(); k++; end
        check_val("reset_align", 32'(p == m_start[0] + 60), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_async_freq_a", 32'(freq_a), 32'd0);
        check_val("rst_async_vld_a",  32'(vld_a),  32'd0);
        check_val("rst_async_ovf_a",  32'(ovf_a),  32'd0);
        check_val("rst_async_busy_a", 32'(busy_a), 32'd0);
        check_val("rst_async_freq_b", 32'(freq_b), 32'd0);
        check_val("rst_async_busy_b", 32'(busy_b), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!vld_a && k < 300);
        check_val("rst_first_vld_latency", 32'(k), 32'd101);

        // Randomised segments with random enable toggling
        for (int s = 0; s < 12; s++) begin
            per = int'($urandom_range(2, 20));
            case ($urandom_range(0, 2))
                0: begin g_mode = 0; g_const = 1'($urandom_range(0, 1)); end
                1: set_square(per);
                default: g_mode = 2;
            endcase
            for (int c = 0; c < int'($urandom_range(40, 400)); c++) begin
                if ($urandom_range(0, 99) < 2) en = ~en;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter FREQ_SYSCLK, default 12_000_000, system clock frequency in Hz; documentation only, no logic depends on it.
REQ-002 Parameter GATE_CYCLES, default 12_000_000, measurement window length in clk_sys_i cycles; legal range 2 to 2^25-1.
REQ-003 Parameter CNT_WIDTH, default 24, width of the edge counter and result.
REQ-004 clk_sys_i  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 sig_i  input  1  signal to measure, asynchronous to clk_sys_i.
REQ-007 en_i  input  1  measurement enable, level-sensitive.
REQ-008 freq_o  output  CNT_WIDTH  rising-edge count of the last completed window.
REQ-009 freq_vld_o  output  1  one-cycle pulse when freq_o is updated.
REQ-010 ovf_o  output  1  the last completed window saturated the edge count.
REQ-011 busy_o  output  1  a window is in progress.

Function
REQ-012 sig_i SHALL pass through a 2-flop synchronizer, then a third flop; a rising edge is sync2=1 AND prev=0, giving a 3-cycle detect latency.
REQ-013 The synchronizer and edge detector SHALL run continuously, independent of state.
REQ-014 The FSM SHALL have exactly two states: IDLE and GATE.
REQ-015 IDLE, en_i=1 -> GATE on the next edge; the gate counter (25 bit) and edge counter SHALL be cleared on entry.
REQ-016 GATE: the gate counter SHALL increment every cycle.
REQ-017 GATE: the edge counter SHALL increment once per detected edge and saturate at 2^CNT_WIDTH-1.
REQ-018 An edge detected while the edge counter is already at maximum SHALL set an internal overflow flag for the current window.
REQ-019 An edge is counted in the window whose GATE cycle detects it; edges detected in IDLE are discarded.
REQ-020 In the GATE cycle where gate counter = GATE_CYCLES-1, the window SHALL complete: freq_o loads edge count plus that cycle's edge (saturating), and ovf_o loads the overflow flag (including that cycle).
REQ-021 freq_vld_o SHALL pulse high for exactly the one cycle after that window-end cycle, coincident with the new freq_o and ovf_o values.
REQ-022 At window end with en_i=1, the next window SHALL start in the following cycle with counters cleared; there are no dead cycles, and the window period is exactly GATE_CYCLES.
REQ-023 At window end with en_i=0, the FSM SHALL return to IDLE.
REQ-024 en_i=0 during GATE before window end SHALL abort: -> IDLE next cycle, no freq_vld_o, and freq_o/ovf_o keep their previous values.
REQ-025 busy_o SHALL be 1 exactly when the state is GATE.
REQ-026 freq_o and ovf_o SHALL change only on window completion or reset.

Reset
REQ-027 rst_n_i low SHALL immediately force state IDLE; all counters, synchronizer flops, freq_o, ovf_o, freq_vld_o and busy_o SHALL be 0.
REQ-028 Reset mid-window SHALL discard the partial window; after release, no freq_vld_o occurs until a full new window completes.

Verification (GATE_CYCLES=100, CNT_WIDTH=8 unless stated)
REQ-029 Bench SHALL cover:
- en_i=1 held, sig_i square wave with a 10-cycle period -> freq_o=10 (+/-1 for phase), ovf_o=0, freq_vld_o pulses every 100 cycles.
- GATE_CYCLES=1000, sig_i period 2 cycles (500 edges) -> freq_o=255, ovf_o=1; next window at period 10 -> freq_o=100, ovf_o=0.
- sig_i held constant 1 -> freq_o=0, ovf_o=0, freq_vld_o still pulses every 100 cycles.
- en_i dropped at cycle 50 of a window -> busy_o=0 next cycle, no freq_vld_o, freq_o unchanged from the prior window.
- rst_n_i pulsed low at cycle 60 -> all outputs 0 asynchronously; first freq_vld_o exactly 101 cycles after the first clock edge with en_i=1 post-release.
- en_i asserted from IDLE -> busy_o=1 one cycle later; a sig_i edge 2 cycles before window end is counted in the following window.
